// File: rtl/mem_array_pkg.sv
// Shared constants, FSM state type and address helper for the block-memory
// read path that rebuilds 8x8 coefficient arrays.
package mem_array_pkg;

    localparam int BLOCK_DIM      = 8;
    localparam int BLOCK_WORDS    = BLOCK_DIM * BLOCK_DIM;
    localparam int WORD_IDX_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } state_t;

    // Word w of block b sits at b*64 + w, matching the writer's row-major packing.
    function automatic int unsigned block_word_addr(input int unsigned blk,
                                                    input int unsigned word);
        return blk * BLOCK_WORDS + word;
    endfunction

endpackage

// File: rtl/mem_to_array.sv
// Fetches consecutive 8x8 blocks from the flat block memory, one word per cycle,
// and presents each reassembled block downstream under a valid/ready handshake.
module mem_to_array
    import mem_array_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 2048,
    parameter int ADDR_WIDTH    = 11,
    parameter int BLK_IDX_WIDTH = 5
) (
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [BLK_IDX_WIDTH-1:0]                           start_block,
    input  logic [5:0]                                         block_count,
    output logic                                               busy,
    output logic                                               mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                              mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]                              mem_rd_data,
    output logic                                               output_valid,
    input  logic                                               output_ready,
    output logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][DATA_WIDTH-1:0] output_data_array,
    output logic [BLK_IDX_WIDTH-1:0]                           output_block_index,
    output logic                                               done
);

    localparam int                        NUM_BLOCKS = MEM_DEPTH / BLOCK_WORDS;
    localparam logic [WORD_IDX_WIDTH-1:0] LAST_WORD  = WORD_IDX_WIDTH'(BLOCK_WORDS - 1);
    localparam logic [BLK_IDX_WIDTH-1:0]  LAST_BLOCK = BLK_IDX_WIDTH'(NUM_BLOCKS - 1);

    state_t                      state;
    state_t                      next_state;
    logic [BLK_IDX_WIDTH-1:0]    cur_block;
    logic [BLK_IDX_WIDTH-1:0]    next_block;
    logic [5:0]                  remaining;
    logic [WORD_IDX_WIDTH-1:0]   rd_word;
    logic                        rd_complete;
    logic                        cap_en;
    logic [WORD_IDX_WIDTH-1:0]   cap_word;
    logic                        req_accept;
    logic                        advance;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation ordering cannot change behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (block_count == 6'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (cap_en && cap_word == LAST_WORD) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (output_ready) begin
                    next_state = (remaining > 6'd1) ? FETCH : DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign req_accept = (state == IDLE) && start && (block_count != 6'd0);
    assign advance    = (state == HOLD) && output_ready && (remaining > 6'd1);
    assign next_block = (cur_block == LAST_BLOCK) ? '0 : cur_block + 1'b1;

    assign busy               = (state != IDLE);
    assign output_valid       = (state == HOLD);
    assign done               = (state == DONE);
    assign mem_rd_en          = (state == FETCH) && !rd_complete;
    assign mem_rd_addr        = ADDR_WIDTH'(block_word_addr(32'(cur_block), 32'(rd_word)));
    assign output_block_index = cur_block;

    // Capture runs one cycle behind the read strobe to match the memory latency.
    // NOTE: the assembly array is reset along with the control state because
    // every element must read zero after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_block         <= '0;
            remaining         <= '0;
            rd_word           <= '0;
            rd_complete       <= 1'b0;
            cap_en            <= 1'b0;
            cap_word          <= '0;
            output_data_array <= '0;
        end else begin
            cap_en   <= mem_rd_en;
            cap_word <= rd_word;
            if (cap_en) begin
                output_data_array[cap_word[5:3]][cap_word[2:0]] <= mem_rd_data;
            end

            if (req_accept) begin
                cur_block   <= start_block;
                remaining   <= block_count;
                rd_word     <= '0;
                rd_complete <= 1'b0;
            end else if (advance) begin
                cur_block   <= next_block;
                remaining   <= remaining - 6'd1;
                rd_word     <= '0;
                rd_complete <= 1'b0;
            end else if (mem_rd_en) begin
                rd_word <= rd_word + 1'b1;
                if (rd_word == LAST_WORD) begin
                    rd_complete <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_to_array.sv
// Self-checking bench for mem_to_array: table-driven requests, reset and
// busy-start corner cases, then randomized requests against a memory model.
module tb_mem_to_array;
    import mem_array_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int BW    = 5;
    localparam int DEPTH = 2048;

    typedef struct {
        int          sb;
        int          cnt;
        int          stall;
        bit          poke;
        int          exp_idx0;
        int unsigned exp_e35;
        int          exp_reads;
    } vec_t;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         start = 1'b0;
    logic [BW-1:0]                start_block = '0;
    logic [5:0]                   block_count = '0;
    logic                         busy;
    logic                         mem_rd_en;
    logic [AW-1:0]                mem_rd_addr;
    logic [DW-1:0]                mem_rd_data = '0;
    logic                         output_valid;
    logic                         output_ready = 1'b0;
    logic [7:0][7:0][DW-1:0]      output_data_array;
    logic [BW-1:0]                output_block_index;
    logic                         done;

    logic [DW-1:0] mem [DEPTH];
    int            reads_q[$];
    int            done_cnt   = 0;
    bit            valid_seen = 1'b0;
    int            checks     = 0;
    int            errors     = 0;

    mem_to_array #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .BLK_IDX_WIDTH(BW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .start_block(start_block),
        .block_count(block_count), .busy(busy), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_data_array(output_data_array),
        .output_block_index(output_block_index), .done(done)
    );

    always #5 clock = ~clock;

    // Memory with one-cycle read latency plus a log of every issued read.
    always @(posedge clock) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            reads_q.push_back(int'(mem_rd_addr));
        end
        if (done) done_cnt++;
        if (output_valid) valid_seen = 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit array_ok(input int blk);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (output_data_array[r][c] !== mem[blk * 64 + r * 8 + c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_request(input int sb, input int cnt, input int stall, input bit poke,
                              input string tag, output logic [31:0] e35, output int idx0);
        int lat;
        int eb;
        int base_done;
        bit ok;
        reads_q.delete();
        base_done  = done_cnt;
        valid_seen = 1'b0;
        e35        = '0;
        idx0       = 0;
        @(negedge clock);
        start       = 1'b1;
        start_block = BW'(sb);
        block_count = 6'(cnt);
        @(negedge clock);
        start = 1'b0;
        if (cnt == 0) check(done === 1'b1, {tag, " done_after_start"}, done, 1);
        for (int i = 0; i < cnt; i++) begin
            eb  = (sb + i) % 32;
            lat = 0;
            while (!output_valid && lat < 300) begin
                @(negedge clock);
                lat++;
            end
            check(lat == 65, $sformatf("%s blk%0d latency", tag, i), lat, 65);
            if (!output_valid) break;
            check(output_block_index == BW'(eb), $sformatf("%s blk%0d index", tag, i),
                  output_block_index, eb);
            check(array_ok(eb), $sformatf("%s blk%0d array", tag, i), 0, 1);
            if (i == 0) begin
                e35  = output_data_array[3][5];
                idx0 = int'(output_block_index);
            end
            ok = 1'b1;
            for (int s = 0; s < stall; s++) begin
                start = (poke && s == 2);
                if (start) begin
                    start_block = BW'(sb + 5);
                    block_count = 6'd7;
                end
                @(negedge clock);
                ok &= output_valid && (output_block_index == BW'(eb)) && !mem_rd_en && array_ok(eb);
            end
            start = 1'b0;
            if (stall > 0) check(ok, $sformatf("%s blk%0d stall_stable", tag, i), ok, 1);
            output_ready = 1'b1;
            @(negedge clock);
            output_ready = 1'b0;
            if (i < cnt - 1)
                check(!output_valid && mem_rd_en && mem_rd_addr == AW'(((eb + 1) % 32) * 64),
                      $sformatf("%s blk%0d next_fetch_addr", tag, i), mem_rd_addr, ((eb + 1) % 32) * 64);
            else
                check(done && !output_valid, $sformatf("%s done_pulse", tag), done, 1);
        end
        @(negedge clock);
        check(!busy && !done, {tag, " idle_after"}, busy, 0);
        check(done_cnt - base_done == 1, {tag, " done_count"}, done_cnt - base_done, 1);
        if (cnt == 0) check(!valid_seen, {tag, " no_valid"}, valid_seen, 0);
        ok = (reads_q.size() == cnt * 64);
        if (ok)
            for (int k = 0; k < cnt * 64; k++)
                if (reads_q[k] != ((sb + k / 64) % 32) * 64 + k % 64) ok = 1'b0;
        check(ok, {tag, " read_addresses"}, reads_q.size(), cnt * 64);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] e35;
        int          idx0;
        int          lat;
        bit          zero_ok;

        for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
        repeat (3) @(negedge clock);
        zero_ok = !busy && !mem_rd_en && mem_rd_addr == '0 && !output_valid && !done
                  && output_block_index == '0 && output_data_array == '0;
        check(zero_ok, "reset_outputs_zero", 0, 1);
        reset = 1'b0;
        @(negedge clock);
        check(!busy && !output_valid, "idle_after_reset", busy, 0);

        vecs[0] = '{sb: 0,  cnt: 1,  stall: 0,  poke: 0, exp_idx0: 0,  exp_e35: 29,   exp_reads: 64};
        vecs[1] = '{sb: 31, cnt: 2,  stall: 0,  poke: 0, exp_idx0: 31, exp_e35: 2013, exp_reads: 128};
        vecs[2] = '{sb: 7,  cnt: 2,  stall: 20, poke: 0, exp_idx0: 7,  exp_e35: 477,  exp_reads: 128};
        vecs[3] = '{sb: 9,  cnt: 0,  stall: 0,  poke: 0, exp_idx0: 0,  exp_e35: 0,    exp_reads: 0};
        vecs[4] = '{sb: 12, cnt: 3,  stall: 5,  poke: 1, exp_idx0: 12, exp_e35: 797,  exp_reads: 192};
        vecs[5] = '{sb: 28, cnt: 34, stall: 0,  poke: 0, exp_idx0: 28, exp_e35: 1821, exp_reads: 2176};

        for (int i = 0; i < 6; i++) begin
            do_request(vecs[i].sb, vecs[i].cnt, vecs[i].stall, vecs[i].poke,
                       $sformatf("vec%0d", i), e35, idx0);
            if (vecs[i].cnt > 0) begin
                check(e35 == vecs[i].exp_e35, $sformatf("vec%0d elem35", i), e35, vecs[i].exp_e35);
                check(idx0 == vecs[i].exp_idx0, $sformatf("vec%0d first_index", i), idx0, vecs[i].exp_idx0);
            end
            check(reads_q.size() == vecs[i].exp_reads, $sformatf("vec%0d read_count", i),
                  reads_q.size(), vecs[i].exp_reads);
        end

        // Reset in the middle of a fetch, then a clean request for block 2.
        reads_q.delete();
        @(negedge clock);
        start       = 1'b1;
        start_block = 5'd5;
        block_count = 6'd3;
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        while (reads_q.size() < 30 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check(reads_q.size() == 30, "midfetch_reads_before_reset", reads_q.size(), 30);
        reset = 1'b1;
        @(negedge clock);
        zero_ok = !busy && !mem_rd_en && mem_rd_addr == '0 && !output_valid && !done
                  && output_block_index == '0 && output_data_array == '0;
        check(zero_ok, "midfetch_reset_outputs_zero", 0, 1);
        reset = 1'b0;
        @(negedge clock);
        check(output_data_array == '0 && !busy, "late_data_ignored", busy, 0);
        do_request(2, 1, 0, 1'b0, "after_reset", e35, idx0);
        check(e35 == 32'd157, "after_reset elem35", e35, 157);

        // Randomized requests against freshly randomized memory contents.
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
            do_request(int'($urandom_range(0, 31)), int'($urandom_range(1, 3)),
                       int'($urandom_range(0, 4)), 1'b0, $sformatf("rand%0d", r), e35, idx0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_to_array.md
Name: mem_to_array

Overview:
- Read-side counterpart of the block writer that packs 8x8 coefficient arrays into the flat 2048-word block memory.
- Fetches one or more consecutive 8x8 blocks from a single-read-port memory, one word per cycle.
- Reassembles each block into an 8x8 array and presents it downstream with a valid/ready handshake.
- Sits between the block memory and the next encoder stage (entropy/bitstream packing).

Parameters:
- DATA_WIDTH, 32, width of one memory word / array element.
- MEM_DEPTH, 2048, memory words; must be a multiple of 64.
- ADDR_WIDTH, 11, log2(MEM_DEPTH).
- BLK_IDX_WIDTH, 5, log2(MEM_DEPTH/64).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- start_block  in  BLK_IDX_WIDTH  first block index to read.
- block_count  in  6  number of blocks to read (0..63).
- busy  out  1  high in any state other than IDLE.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  word address.
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- output_valid  out  1  output_data_array holds a complete block.
- output_ready  in  1  downstream accepts the block.
- output_data_array  out  DATA_WIDTH x [8][8]  assembled block, [row][col].
- output_block_index  out  BLK_IDX_WIDTH  index of the block being presented.
- done  out  1  one-cycle pulse when the request completes.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0, including every array element. Any in-flight request is discarded, and a late mem_rd_data is ignored. Reset overrides start.
- Layout: word w (0..63) of block b is at address b*64+w, with row = w/8 and col = w%8. This matches the writer's j*8+k packing.
- State IDLE:
  - start=1 with block_count=0 -> DONE; no reads issued.
  - start=1 with block_count>0 -> latch cur_block=start_block and remaining=block_count, then go to FETCH.
- State FETCH:
  - mem_rd_en=1 for exactly 64 consecutive cycles; mem_rd_addr = cur_block*64 + w, with w = 0..63 ascending.
  - Data is captured one cycle later into array[w/8][w%8]. A delayed rd_en/word index drives the capture.
  - After word 63 is captured -> HOLD.
- State HOLD: output_valid=1, and output_data_array / output_block_index stay stable until output_valid && output_ready.
  - On handshake with remaining>1: decrement remaining; cur_block = cur_block+1 mod 32 (wraps 31->0); output_valid drops; go to FETCH.
  - On handshake with remaining==1 -> DONE.
- State DONE: done=1 for one cycle, output_valid=0 -> IDLE.
- Latency:
  - start sampled at edge T -> reads at T+1..T+64 -> output_valid first high in the cycle after edge T+65.
  - Handshake at edge H -> next block's first read at H+1.
  - Throughput is one block per 66 cycles plus downstream stall.
- output_ready with output_valid=0 has no effect. start while busy is ignored (no queueing).
- block_count>32 is legal; blocks are re-read modulo 32.
- output_data_array keeps its last block after handshake until it is overwritten word by word during the next FETCH. Consumers must use it only while output_valid=1.

Decomposition:
- Package mem_array_pkg holds:
  - BLOCK_DIM=8 and BLOCK_WORDS=64;
  - state enum {IDLE, FETCH, HOLD, DONE};
  - an address helper function (block, word) -> address.
- Single module; the FSM, address counter and assembly register are tightly coupled, so no sub-module.

Test Plan:
- Preload mem[a]=a for all a; start_block=0, block_count=1, output_ready=1 -> reads at 0..63, output_valid 66 cycles after start, array[3][5]=29, done pulse once.
- start_block=31, block_count=2 -> blocks 31 then 0 are presented; first array[0][0]=1984, second array[0][0]=0, index 31 then 0.
- Hold output_ready=0 for 20 cycles in HOLD -> array and index stable, no mem_rd_en, then handshake -> next FETCH starts the next cycle.
- block_count=0 -> done one cycle after start, zero reads, output_valid never high.
- Assert reset during FETCH (word 30) -> next cycle all outputs 0, IDLE; the subsequent start=1 block 2 reads addresses 128..191 correctly.
- Pulse start while busy (during HOLD) -> ignored; the remaining sequence is unchanged and exactly one done pulse occurs.
